// File: rtl/cpu54_pkg.sv
// Shared definitions for the cpu54 fetch stage: reset vector, datapath widths and
// the fetch FSM state type.
package cpu54_pkg;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   typedef enum logic {
      IDLE,
      WAIT
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs for the decoder.
// A flush empties it in one cycle and overrides any push or pop in that cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0) && !flush;
   assign do_push = push && ((count != FULL) || do_pop) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight and
// hands buffered words to decode; redirects flush the buffer and drop stale data.
module instr_fetch_unit #(
   parameter logic [cpu54_pkg::ADDR_W-1:0] RESET_PC = cpu54_pkg::RESET_PC,
   parameter int                           DEPTH    = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   output logic                            imem_req,
   output logic [cpu54_pkg::ADDR_W-1:0]    imem_addr,
   input  logic                            imem_ack,
   input  logic [cpu54_pkg::INSTR_W-1:0]   imem_rdata,
   input  logic                            redirect_valid,
   input  logic [cpu54_pkg::ADDR_W-1:0]    redirect_pc,
   output logic                            ir_valid,
   input  logic                            ir_ready,
   output logic [cpu54_pkg::INSTR_W-1:0]   ir_instr,
   output logic [cpu54_pkg::ADDR_W-1:0]    ir_pc
);

   import cpu54_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam int ENTRY_W = ADDR_W + INSTR_W;

   fetch_state_t        state_q;
   fetch_state_t        state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [ADDR_W-1:0]   redirect_target;
   logic                req_d;
   logic                drop_q;
   logic                drop_d;
   logic                push;
   logic                pop;
   logic [CNT_W-1:0]    count;
   logic [ENTRY_W-1:0]  head;
   logic [ENTRY_W-1:0]  hold_q;

   assign redirect_target = redirect_pc & ~ADDR_W'(3);

   // drop marks an in-flight response that belongs to a path abandoned by a redirect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = imem_addr;
      req_d   = imem_req;
      drop_d  = drop_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
            end else if (count < DEPTH_C) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               drop_d  = 1'b0;
               state_d = IDLE;
               if (redirect_valid) begin
                  pc_d = redirect_target;
               end else if (!drop_q) begin
                  push = 1'b1;
                  pc_d = pc_q + ADDR_W'(4);
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
               pc_d   = redirect_target;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         drop_q    <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         imem_req  <= req_d;
         imem_addr <= addr_d;
         drop_q    <= drop_d;
         if (ir_valid) begin
            hold_q <= head;
         end
      end
   end

   assign pop = ir_valid && ir_ready;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({imem_addr, imem_rdata}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (count),
      .head      (head)
   );

   // Outputs keep showing the last presented entry while the buffer is empty.
   assign ir_valid = (count != '0);
   assign ir_pc    = ir_valid ? head[ENTRY_W-1:INSTR_W] : hold_q[ENTRY_W-1:INSTR_W];
   assign ir_instr = ir_valid ? head[INSTR_W-1:0]       : hold_q[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an instruction-memory responder, a
// queue-based model of the decode buffer, and directed redirect/reset scenarios.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic [31:0] ir_instr;
   logic [31:0] ir_pc;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_q[$];
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] out_addr = '0;
   bit          outstanding = 1'b0;
   bit          mdrop = 1'b0;
   int          pre_size = 0;
   logic [31:0] req_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] last_instr = '0;
   logic [31:0] last_pc = '0;
   logic [31:0] watch_pc = 32'hFFFF_FFFF;
   bit          saw_watch = 1'b0;
   int          ack_delay = 1;
   bit          ack_enable = 1'b1;
   int          wait_cnt = 0;

   instr_fetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .ir_instr       (ir_instr),
      .ir_pc          (ir_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'hA5C3_0F96;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      ir_ready       = rdy;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      req_log.delete();
      pop_log.delete();
      saw_watch = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic expect_next_req(input logic [31:0] addr, input string name);
      int n = 0;
      while (req_log.size() == 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (req_log.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: no request seen, required addr=%h", name, addr);
      end else begin
         check_output(name, req_log.pop_front(), addr);
      end
   endtask

   // Instruction memory: answers each request after ack_delay cycles, one ack per request.
   initial forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (!rst_n) begin
         wait_cnt = 0;
      end else if (imem_req && ack_enable) begin
         if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt   = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // Model: decode buffer as a queue, next fetch PC, and whether the in-flight word is stale.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_pc      = RST_PC;
         outstanding = 1'b0;
         mdrop       = 1'b0;
         pre_size    = 0;
      end else begin
         pre_size = exp_q.size();
         if (redirect_valid) begin
            exp_q.delete();
            if (outstanding) begin
               if (imem_ack) begin
                  outstanding = 1'b0;
                  mdrop       = 1'b0;
               end else begin
                  mdrop = 1'b1;
               end
            end
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (ir_ready && exp_q.size() > 0) begin
               pop_log.push_back(exp_q[0][63:32]);
               void'(exp_q.pop_front());
            end
            if (imem_ack && outstanding) begin
               if (!mdrop) begin
                  exp_q.push_back({exp_pc, mem_word(exp_pc)});
                  exp_pc = exp_pc + 32'd4;
               end
               outstanding = 1'b0;
               mdrop       = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check_output("rst_req", 32'(imem_req), 32'd0);
         check_output("rst_addr", imem_addr, RST_PC);
         check_output("rst_valid", 32'(ir_valid), 32'd0);
         check_output("rst_instr", ir_instr, 32'd0);
         check_output("rst_pc", ir_pc, 32'd0);
         last_instr = '0;
         last_pc    = '0;
      end else begin
         check_output("ir_valid", 32'(ir_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check_output("ir_instr", ir_instr, exp_q[0][31:0]);
            check_output("ir_pc", ir_pc, exp_q[0][63:32]);
            last_instr = exp_q[0][31:0];
            last_pc    = exp_q[0][63:32];
         end else begin
            check_output("hold_instr", ir_instr, last_instr);
            check_output("hold_pc", ir_pc, last_pc);
         end
         if (imem_req) begin
            if (!outstanding) begin
               check_output("req_addr", imem_addr, exp_pc);
               check_output("issue_room", 32'(pre_size < DEPTH), 32'd1);
               outstanding = 1'b1;
               out_addr    = exp_pc;
               req_log.push_back(imem_addr);
            end else begin
               check_output("addr_stable", imem_addr, out_addr);
            end
         end else if (outstanding) begin
            check_output("req_held", 32'(imem_req), 32'd1);
         end
         if (ir_valid && ir_pc == watch_pc) begin
            saw_watch = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 rst_n = 1'b0;
      apply_reset();

      // Straight-line fetch with a prompt memory and a ready decoder.
      ack_delay = 1;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0000, "t1_req0");
      expect_next_req(32'h0040_0004, "t1_req1");
      expect_next_req(32'h0040_0008, "t1_req2");
      repeat (4) @(negedge clk);
      #1;
      check_output("t1_pop_count", 32'(pop_log.size() >= 2), 32'd1);
      if (pop_log.size() >= 2) begin
         check_output("t1_pop0", pop_log[0], 32'h0040_0000);
         check_output("t1_pop1", pop_log[1], 32'h0040_0004);
      end

      // Decoder stalled: buffer fills to two entries and fetch pauses.
      apply_reset();
      expect_next_req(32'h0040_0000, "t2_req0");
      expect_next_req(32'h0040_0004, "t2_req1");
      repeat (6) @(negedge clk);
      #1;
      check_output("t2_buffered", 32'(exp_q.size()), 32'd2);
      check_output("t2_valid", 32'(ir_valid), 32'd1);
      check_output("t2_req_idle", 32'(imem_req), 32'd0);
      check_output("t2_no_new_req", 32'(req_log.size()), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0008, "t2_resume");
      check_output("t2_first_pop", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0040_0000);

      // Redirect while waiting on a slow response: stale word must vanish.
      apply_reset();
      ack_delay = 3;
      watch_pc  = 32'h0040_0004;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0000, "t3_req0");
      expect_next_req(32'h0040_0004, "t3_req1");
      apply_stimulus(1'b1, 32'h0040_0100, 1'b1);
      @(negedge clk);
      #1;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0100, "t3_redirect_req");
      repeat (6) @(negedge clk);
      #1;
      check_output("t3_stale_hidden", 32'(saw_watch), 32'd0);
      watch_pc = 32'hFFFF_FFFF;

      // Redirect coinciding with an ack and a pop on a one-entry buffer.
      apply_reset();
      ack_delay = 1;
      expect_next_req(32'h0040_0000, "t4_req0");
      expect_next_req(32'h0040_0004, "t4_req1");
      @(negedge clk);
      #1;
      check_output("t4_ack_now", 32'(imem_ack), 32'd1);
      check_output("t4_one_entry", 32'(ir_valid), 32'd1);
      apply_stimulus(1'b1, 32'h0040_0200, 1'b1);
      @(negedge clk);
      #1;
      check_output("t4_flushed", 32'(ir_valid), 32'd0);
      check_output("t4_no_pop", 32'(pop_log.size()), 32'd0);
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0200, "t4_redirect_req");

      // PC wrap and redirect address alignment, with zero-latency acks.
      apply_reset();
      ack_delay = 0;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0000, "t5_req0");
      req_log.delete();
      apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
      @(negedge clk);
      #1;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'hFFFF_FFFC, "t5_top");
      expect_next_req(32'h0000_0000, "t5_wrap");
      req_log.delete();
      apply_stimulus(1'b1, 32'h0040_0103, 1'b1);
      @(negedge clk);
      #1;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(32'h0040_0100, "t5_align");
      expect_next_req(32'h0040_0104, "t5_align_next");

      // Reset during an outstanding request, late ack ignored, clean restart.
      apply_reset();
      ack_delay = 5;
      apply_stimulus(1'b0, '0, 1'b1);
      expect_next_req(RST_PC, "t6_req0");
      rst_n = 1'b0;
      #1;
      check_output("t6_req_drop", 32'(imem_req), 32'd0);
      ack_enable = 1'b0;
      @(negedge clk);
      #1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      check_output("t6_valid_low", 32'(ir_valid), 32'd0);
      req_log.delete();
      pop_log.delete();
      ack_delay  = 1;
      imem_ack   = 1'b1;
      ack_enable = 1'b1;
      rst_n      = 1'b1;
      expect_next_req(RST_PC, "t6_restart0");
      expect_next_req(RST_PC + 32'd4, "t6_restart1");

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
